// File: rtl/pkt_client_csr.sv
// Avalon-MM CSR block for the packet client: scratch, control, packet count, status, TX counter.
// Build option PKT_CLIENT_CSR_WRRESP_EN enables the write-response channel.
module pkt_client_csr (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  avmm_address,
    input  logic        avmm_write,
    input  logic        avmm_read,
    input  logic [31:0] avmm_writedata,
    input  logic [3:0]  avmm_byteenable,
    input  logic        avmm_burstcount,
    output logic        avmm_waitrequest,
    output logic [31:0] avmm_readdata,
    output logic        avmm_readdatavalid,
    output logic [1:0]  avmm_response,
    output logic        avmm_writeresponsevalid,
    output logic        o_start,
    output logic        o_loopback_en,
    output logic [31:0] o_pkt_num,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic        i_tx_pkt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_wr;
    logic [5:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_scratch;
    logic        r_loopback;
    logic [31:0] r_pkt_num;
    logic        r_done;
    logic [31:0] r_tx_cnt;
    logic        r_start;

    logic [31:0] r_rdata;
    logic        r_rdvalid;
    logic [1:0]  r_resp;

    logic        w_accept;
    logic        w_mapped;
    logic        w_wr_fire;
    logic [31:0] w_mask;
    logic        w_cnt_clr;
    logic        w_start_set;
    logic        w_done_w1c;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_unused = ^{avmm_burstcount, avmm_address[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (avmm_write || avmm_read) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept    = (r_state == ST_ACK);
    assign w_mapped    = (r_addr <= 6'd4);
    assign w_wr_fire   = w_accept && r_is_wr && w_mapped;
    assign w_mask      = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
    assign w_cnt_clr   = w_wr_fire && (r_addr == 6'd1) && r_be[0] && r_wdata[2];
    assign w_start_set = w_wr_fire && (r_addr == 6'd1) && r_be[0] && r_wdata[0];
    assign w_done_w1c  = w_wr_fire && (r_addr == 6'd3) && r_be[0] && r_wdata[1];

    always_comb begin
        w_rd_mux = 32'hDEADBEEF;
        case (r_addr)
            6'd0:    w_rd_mux = r_scratch;
            6'd1:    w_rd_mux = {30'd0, r_loopback, 1'b0};
            6'd2:    w_rd_mux = r_pkt_num;
            6'd3:    w_rd_mux = {30'd0, r_done, i_busy};
            6'd4:    w_rd_mux = r_tx_cnt;
            default: w_rd_mux = 32'hDEADBEEF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Write wins over a simultaneous read: the read is simply dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_is_wr <= 1'b0;
            r_addr  <= 6'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (r_state == ST_IDLE && (avmm_write || avmm_read)) begin
            r_is_wr <= avmm_write;
            r_addr  <= avmm_address[7:2];
            r_wdata <= avmm_writedata;
            r_be    <= avmm_byteenable;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scratch  <= 32'd0;
            r_loopback <= 1'b0;
            r_pkt_num  <= 32'd0;
            r_done     <= 1'b0;
            r_tx_cnt   <= 32'd0;
            r_start    <= 1'b0;
        end else begin
            if (w_wr_fire && r_addr == 6'd0)
                r_scratch <= (r_scratch & ~w_mask) | (r_wdata & w_mask);
            if (w_wr_fire && r_addr == 6'd2)
                r_pkt_num <= (r_pkt_num & ~w_mask) | (r_wdata & w_mask);
            if (w_wr_fire && r_addr == 6'd1 && r_be[0])
                r_loopback <= r_wdata[1];
            r_start <= w_start_set;
            // A new done event outranks a concurrent clear.
            r_done  <= i_done | (r_done & ~w_done_w1c);
            if (w_cnt_clr)
                r_tx_cnt <= 32'd0;
            else if (i_tx_pkt && r_tx_cnt != 32'hFFFF_FFFF)
                r_tx_cnt <= r_tx_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata   <= 32'd0;
            r_rdvalid <= 1'b0;
            r_resp    <= 2'b00;
        end else begin
            r_rdata   <= 32'd0;
            r_rdvalid <= 1'b0;
            r_resp    <= 2'b00;
            if (w_accept) begin
                r_resp <= w_mapped ? 2'b00 : 2'b10;
                if (!r_is_wr) begin
                    r_rdvalid <= 1'b1;
                    r_rdata   <= w_rd_mux;
                end
            end
        end
    end

`ifdef PKT_CLIENT_CSR_WRRESP_EN
    logic r_wrvalid;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_wrvalid <= 1'b0;
        else       r_wrvalid <= w_accept && r_is_wr;
    end
    assign avmm_writeresponsevalid = r_wrvalid;
`else
    assign avmm_writeresponsevalid = 1'b0;
`endif

    assign avmm_waitrequest   = (r_state != ST_ACK);
    assign avmm_readdata      = r_rdata;
    assign avmm_readdatavalid = r_rdvalid;
    assign avmm_response      = r_resp;
    assign o_start            = r_start;
    assign o_loopback_en      = r_loopback;
    assign o_pkt_num          = r_pkt_num;

endmodule

// File: tb/tb_pkt_client_csr.sv
// Self-checking bench for pkt_client_csr: transaction-level register model, per-cycle
// comparison of every output, directed corner cases and randomized accesses/events.
module tb_pkt_client_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        wr, rd;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        burst;
    logic        waitreq, rdv, wrv, o_start, o_lb;
    logic [31:0] rdata, o_pkt;
    logic [1:0]  resp;
    logic        busy, done, tx;

    always #5 clk = ~clk;

    pkt_client_csr dut (
        .i_clk(clk), .i_rst(rst),
        .avmm_address(addr), .avmm_write(wr), .avmm_read(rd),
        .avmm_writedata(wd), .avmm_byteenable(be), .avmm_burstcount(burst),
        .avmm_waitrequest(waitreq), .avmm_readdata(rdata), .avmm_readdatavalid(rdv),
        .avmm_response(resp), .avmm_writeresponsevalid(wrv),
        .o_start(o_start), .o_loopback_en(o_lb), .o_pkt_num(o_pkt),
        .i_busy(busy), .i_done(done), .i_tx_pkt(tx)
    );

    int n_chk = 0;
    int n_err = 0;

    // register model
    logic [31:0] m_scr, m_pkt, m_tx;
    logic        m_lb, m_done;
    // access timeline: 0 = no access, 1 = accept cycle, 2 = response cycle
    int          ph;
    logic        p_wr;
    logic [7:0]  p_addr;
    logic [31:0] p_wd;
    logic [3:0]  p_be;
    // expected outputs for the current cycle
    logic        e_wait, e_rdv, e_wrv, e_start;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    bit          rnd_ev;
    // values captured by access()
    logic [31:0] cap_rdata;
    logic [1:0]  cap_resp;
    logic        cap_ackwait, cap_rdv, cap_wrv, cap_start;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [7:0] a, input logic busy_v);
        case (a[7:2])
            6'd0:    return m_scr;
            6'd1:    return {30'd0, m_lb, 1'b0};
            6'd2:    return m_pkt;
            6'd3:    return {30'd0, m_done, busy_v};
            6'd4:    return m_tx;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic tick();
        logic        clr, w1c;
        logic [31:0] msk;
        if (rnd_ev) begin
            busy = 1'($urandom_range(0, 1));
            done = ($urandom_range(0, 7) == 0);
            tx   = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        clr = 1'b0; w1c = 1'b0;
        e_start = 1'b0; e_rdv = 1'b0; e_wrv = 1'b0; e_rdata = 32'd0; e_resp = 2'b00;
        if (rst) begin
            m_scr = 0; m_pkt = 0; m_tx = 0; m_lb = 0; m_done = 0; ph = 0;
        end else begin
            case (ph)
                0: if (wr || rd) begin
                    ph = 1; p_wr = wr; p_addr = addr; p_wd = wd; p_be = be;
                end
                1: begin
                    ph = 2;
                    e_resp = (p_addr[7:2] > 6'd4) ? 2'b10 : 2'b00;
                    if (p_wr) begin
`ifdef PKT_CLIENT_CSR_WRRESP_EN
                        e_wrv = 1'b1;
`endif
                        msk = {{8{p_be[3]}}, {8{p_be[2]}}, {8{p_be[1]}}, {8{p_be[0]}}};
                        case (p_addr[7:2])
                            6'd0: m_scr = (m_scr & ~msk) | (p_wd & msk);
                            6'd1: if (p_be[0]) begin
                                m_lb = p_wd[1]; e_start = p_wd[0]; clr = p_wd[2];
                            end
                            6'd2: m_pkt = (m_pkt & ~msk) | (p_wd & msk);
                            6'd3: w1c = p_be[0] & p_wd[1];
                            default: ;
                        endcase
                    end else begin
                        e_rdv = 1'b1;
                        e_rdata = rd_model(p_addr, busy);
                    end
                end
                default: ph = 0;
            endcase
            m_done = done | (m_done & ~w1c);
            if (clr) m_tx = 0;
            else if (tx && m_tx != 32'hFFFF_FFFF) m_tx = m_tx + 1;
        end
        e_wait = (ph != 1);
        @(negedge clk);
        chk("waitrequest", 32'(waitreq), 32'(e_wait));
        chk("readdatavalid", 32'(rdv), 32'(e_rdv));
        chk("readdata", rdata, e_rdata);
        chk("response", 32'(resp), 32'(e_resp));
        chk("writeresponsevalid", 32'(wrv), 32'(e_wrv));
        chk("o_start", 32'(o_start), 32'(e_start));
        chk("o_loopback_en", 32'(o_lb), 32'(m_lb));
        chk("o_pkt_num", o_pkt, m_pkt);
    endtask

    task automatic access(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit ack_tx, input bit ack_done);
        wr = w; rd = r; addr = a; wd = d; be = b;
        tick();
        cap_ackwait = waitreq;
        if (!rnd_ev) begin tx = ack_tx; done = ack_done; end
        tick();
        cap_rdata = rdata; cap_resp = resp; cap_rdv = rdv; cap_wrv = wrv; cap_start = o_start;
        wr = 0; rd = 0;
        if (!rnd_ev) begin tx = 0; done = 0; end
        tick();
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        access(0, 1, a, 32'd0, 4'hF, 0, 0);
        chk(nm, cap_rdata, exp);
    endtask

    initial begin
        rst = 1; wr = 0; rd = 0; addr = 0; wd = 0; be = 0; burst = 0;
        busy = 0; done = 0; tx = 0; rnd_ev = 0; ph = 0;
        m_scr = 0; m_pkt = 0; m_tx = 0; m_lb = 0; m_done = 0;
        repeat (3) tick();
        chk("rst_waitrequest", 32'(waitreq), 32'd1);
        chk("rst_pkt_num", o_pkt, 32'd0);
        rst = 0;
        tick();

        access(1, 0, 8'h00, 32'hA5A5A5A5, 4'hF, 0, 0);
        chk("wr_accept_wait", 32'(cap_ackwait), 32'd0);
        access(0, 1, 8'h00, 32'd0, 4'hF, 0, 0);
        chk("rd_accept_wait", 32'(cap_ackwait), 32'd0);
        chk("rd_valid", 32'(cap_rdv), 32'd1);
        chk("scratch_rd", cap_rdata, 32'hA5A5A5A5);
        chk("scratch_resp", 32'(cap_resp), 32'd0);

        access(1, 0, 8'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
        access(1, 0, 8'h00, 32'h00000000, 4'h5, 0, 0);
        rd_chk("scratch_be5", 8'h00, 32'hFF00FF00);

        rd_chk("unmapped_rd", 8'h20, 32'hDEADBEEF);
        chk("unmapped_rd_resp", 32'(cap_resp), 32'd2);
        access(1, 0, 8'h20, 32'h12345678, 4'hF, 0, 0);
        chk("unmapped_wr_resp", 32'(cap_resp), 32'd2);
`ifdef PKT_CLIENT_CSR_WRRESP_EN
        chk("unmapped_wr_valid", 32'(cap_wrv), 32'd1);
`endif
        rd_chk("scratch_after_unmapped", 8'h00, 32'hFF00FF00);

        access(1, 0, 8'h04, 32'h3, 4'hF, 0, 0);
        chk("ctrl_start_pulse", 32'(cap_start), 32'd1);
        chk("ctrl_loopback", 32'(o_lb), 32'd1);
        chk("ctrl_start_gone", 32'(o_start), 32'd0);
        rd_chk("ctrl_readback", 8'h04, 32'h2);

        for (int i = 0; i < 5; i++) begin
            tx = 1; tick(); tx = 0; tick();
        end
        rd_chk("tx_count5", 8'h10, 32'd5);
        access(1, 0, 8'h04, 32'h4, 4'hF, 1, 0);
        rd_chk("tx_clear_wins", 8'h10, 32'd0);

        done = 1; tick(); done = 0; tick();
        rd_chk("status_done", 8'h0C, 32'h2);
        access(1, 0, 8'h0C, 32'h2, 4'hF, 0, 1);
        rd_chk("status_set_wins", 8'h0C, 32'h2);
        access(1, 0, 8'h0C, 32'h2, 4'hF, 0, 0);
        busy = 1;
        rd_chk("status_busy_only", 8'h0C, 32'h1);
        busy = 0;

        access(1, 0, 8'h08, 32'hAABBCCDD, 4'hF, 0, 0);
        access(1, 0, 8'h0B, 32'h11223344, 4'h2, 0, 0);
        chk("pkt_num_lane1", o_pkt, 32'hAABB33DD);

        access(1, 1, 8'h00, 32'h5A5A0000, 4'hF, 0, 0);
        chk("wr_rd_no_rdvalid", 32'(cap_rdv), 32'd0);
        rd_chk("wr_priority", 8'h00, 32'h5A5A0000);

        rd = 1; addr = 8'h00; tick();
        rst = 1; tick();
        rd = 0;
        chk("rst_ack_wait", 32'(waitreq), 32'd1);
        chk("rst_ack_rdv", 32'(rdv), 32'd0);
        chk("rst_ack_pkt", o_pkt, 32'd0);
        rst = 0;
        repeat (2) tick();
        rd_chk("rst_ack_scratch", 8'h00, 32'd0);

        rnd_ev = 1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            logic [31:0] d;
            bit w, r;
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
            access(w, r, a, d, 4'($urandom), 0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_ev = 0; tx = 0; done = 0; busy = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pkt_client_csr.md
PKT_CLIENT_CSR -- requirements
Module: pkt_client_csr

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port avmm_address, input, 8 bits: byte address; bits [7:2] select the register, bits [1:0] are ignored.
REQ-004 SHALL have ports avmm_write and avmm_read, input, 1 bit each: the request strobes.
REQ-005 SHALL have port avmm_writedata, input, 32 bits, and port avmm_byteenable, input, 4 bits.
REQ-006 SHALL have port avmm_burstcount, input, 1 bit: ignored; every access is treated as single-beat.
REQ-007 SHALL have ports avmm_waitrequest, output, 1 bit; avmm_readdata, output, 32 bits; avmm_readdatavalid, output, 1 bit.
REQ-008 SHALL have ports avmm_response, output, 2 bits (00 OKAY, 10 SLVERR), and avmm_writeresponsevalid, output, 1 bit.
REQ-009 SHALL have ports o_start, output, 1 bit (one-cycle pulse); o_loopback_en, output, 1 bit; o_pkt_num, output, 32 bits.
REQ-010 SHALL have ports i_busy, input, 1 bit (level); i_done, input, 1 bit (pulse); i_tx_pkt, input, 1 bit (pulse, one per packet sent).

Function
REQ-011 SHALL use this register map: 0x00 SCRATCH (RW); 0x04 CTRL (RW); 0x08 PKT_NUM (RW, drives o_pkt_num); 0x0C STATUS (RO except bit1); 0x10 TX_COUNT (RO).
REQ-012 SHALL define CTRL as: bit0 START, write 1 gives an o_start pulse on the next cycle and reads back 0; bit1 LOOPBACK, a level that drives o_loopback_en; bit2 CNT_CLR, write 1 clears TX_COUNT and reads back 0; all other bits read 0.
REQ-013 SHALL define STATUS as: bit0 the live value of i_busy; bit1 DONE, which is sticky, set by i_done and cleared by writing 1 (write-1-to-clear); all other bits read 0.
REQ-014 SHALL make TX_COUNT a 32-bit counter that increments on each i_tx_pkt and saturates at 0xFFFFFFFF.
REQ-015 SHALL apply byteenable per byte lane to the RW registers; a lane whose enable is 0 keeps its value.
REQ-016 SHALL implement a three-state FSM:
- IDLE: on avmm_write or avmm_read, latch the address and data, then go to ACK.
- ACK: deassert waitrequest for exactly one cycle; this is the accept cycle; go to RESP.
- RESP: for a read, drive readdatavalid=1 with readdata; for a write, drive the write response if enabled (REQ-027); go to IDLE.
REQ-017 SHALL keep avmm_waitrequest at 1 in every state except ACK.
REQ-018 SHALL give each access a latency of exactly 3 cycles from request to response, and accept a new request in the cycle after RESP.
REQ-019 SHALL update registers for a write in the ACK cycle.
REQ-020 SHALL sample readdata in the ACK cycle and present it in RESP.
REQ-021 SHALL, for an access to an unmapped address, ignore the write, return readdata 0xDEADBEEF, and return avmm_response 10; mapped accesses return response 00.
REQ-022 SHALL give the write priority when avmm_write and avmm_read are asserted together; the read is not performed.
REQ-023 SHALL resolve simultaneous events as follows:
- CNT_CLR together with i_tx_pkt: the clear wins, TX_COUNT becomes 0.
- DONE write-1-to-clear together with i_done: the set wins, DONE stays 1.
REQ-024 SHALL hold avmm_readdata, avmm_response and avmm_readdatavalid at 0 outside RESP.

Reset
REQ-025 SHALL, on i_rst, set:
- FSM to IDLE, avmm_waitrequest=1, avmm_readdatavalid=0, avmm_writeresponsevalid=0, avmm_readdata=0, avmm_response=0;
- every register to 0, o_start=0, o_loopback_en=0, o_pkt_num=0.
REQ-026 SHALL, when i_rst is asserted mid-access, abandon the access: no response is issued and no register is updated.

Configuration
REQ-027 SHALL use macro PKT_CLIENT_CSR_WRRESP_EN:
- Defined: in RESP after a write, avmm_writeresponsevalid=1 for one cycle, carrying avmm_response.
- Undefined: avmm_writeresponsevalid is tied to 0, and writes still take 3 cycles.

Verification
REQ-028 SHALL cover: write 0x00=0xA5A5A5A5 with be=0xF, then read 0x00 -> waitrequest low only in the accept cycle, readdatavalid 1 cycle later, data 0xA5A5A5A5, response 00.
REQ-029 SHALL cover: SCRATCH=0xFFFFFFFF, write 0x00=0x00000000 with be=0x5 -> read returns 0xFF00FF00.
REQ-030 SHALL cover: read 0x20 -> readdata 0xDEADBEEF, response 10; with the macro defined, write 0x20 -> writeresponsevalid=1, response 10, no register changes.
REQ-031 SHALL cover: write CTRL=0x3 -> one o_start pulse, o_loopback_en=1; a readback of CTRL returns 0x2.
REQ-032 SHALL cover: 5 i_tx_pkt pulses -> TX_COUNT=5; CTRL=0x4 written in the same cycle as an i_tx_pkt -> TX_COUNT=0.
REQ-033 SHALL cover: i_done pulse -> STATUS bit1=1; W1C in the same cycle as i_done -> bit1 stays 1; i_rst asserted in ACK -> no readdatavalid and all outputs at reset values.
